// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle, shift-add multiply and
// restoring divide sharing a single 2*XLEN working register.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [XLEN-1:0] result,
    output logic            busy,
    output logic            done
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t              r_state;
    logic [CW-1:0]       r_count;
    logic [2:0]          r_func;
    logic [XLEN-1:0]     r_a;
    logic [XLEN-1:0]     r_b;
    logic [2*XLEN-1:0]   r_prod;
    logic                r_neg_q;
    logic                r_neg_r;
    logic [XLEN-1:0]     r_result;
    logic                r_busy;
    logic                r_done;

    logic                w_is_div;
    logic                w_a_signed;
    logic                w_b_signed;
    logic                w_sign_a;
    logic                w_sign_b;
    logic [XLEN-1:0]     w_mag_a;
    logic [XLEN-1:0]     w_mag_b;
    logic                w_div_zero;
    logic                w_overflow;
    logic [XLEN-1:0]     w_exc;
    logic [XLEN:0]       w_add;
    logic [2*XLEN-1:0]   w_mul_next;
    logic [XLEN:0]       w_trial;
    logic [XLEN:0]       w_diff;
    logic [2*XLEN-1:0]   w_div_next;
    logic [2*XLEN-1:0]   w_next;
    logic [2*XLEN-1:0]   w_prod_s;
    logic [XLEN-1:0]     w_quot;
    logic [XLEN-1:0]     w_rem;
    logic [XLEN-1:0]     w_final;

    assign w_is_div   = funct3[2];
    assign w_a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                        (funct3 == 3'b100) || (funct3 == 3'b110);
    assign w_b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    assign w_sign_a   = w_a_signed & op_a[XLEN-1];
    assign w_sign_b   = w_b_signed & op_b[XLEN-1];
    assign w_mag_a    = w_sign_a ? -op_a : op_a;
    assign w_mag_b    = w_sign_b ? -op_b : op_b;

    // Divide corner cases bypass the iteration and return the RISC-V defined values.
    assign w_div_zero = w_is_div && (op_b == '0);
    assign w_overflow = w_is_div && !funct3[0] &&
                        (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    assign w_exc      = w_div_zero ? (funct3[1] ? op_a : '1)
                                   : (funct3[1] ? '0 : op_a);

    assign w_add      = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_a} : '0);
    assign w_mul_next = {w_add, r_prod[XLEN-1:1]};

    // Upper half holds the partial remainder, lower half shifts dividend out / quotient in.
    assign w_trial    = r_prod[2*XLEN-1:XLEN-1];
    assign w_diff     = w_trial - {1'b0, r_b};
    assign w_div_next = w_diff[XLEN] ? {w_trial[XLEN-1:0], r_prod[XLEN-2:0], 1'b0}
                                     : {w_diff[XLEN-1:0],  r_prod[XLEN-2:0], 1'b1};

    assign w_next     = r_func[2] ? w_div_next : w_mul_next;
    assign w_prod_s   = r_neg_q ? -w_next : w_next;
    assign w_quot     = r_neg_q ? -w_next[XLEN-1:0] : w_next[XLEN-1:0];
    assign w_rem      = r_neg_r ? -w_next[2*XLEN-1:XLEN] : w_next[2*XLEN-1:XLEN];

    always_comb begin
        w_final = w_rem;
        case (r_func)
            3'b000:                 w_final = w_prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_final = w_prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_final = w_quot;
            default:                w_final = w_rem;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_func   <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_prod   <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_func  <= funct3;
                        r_a     <= w_mag_a;
                        r_b     <= w_mag_b;
                        r_prod  <= {{XLEN{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
                        r_neg_q <= w_sign_a ^ w_sign_b;
                        r_neg_r <= w_sign_a;
                        r_count <= '0;
                        if (w_div_zero || w_overflow) begin
                            r_result <= w_exc;
                            r_state  <= S_DONE;
                            r_done   <= 1'b1;
                        end else begin
                            r_state <= S_CALC;
                            r_busy  <= 1'b1;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    r_prod  <= w_next;
                    r_count <= r_count + CW'(1);
                    if (r_count == CW'(XLEN-1)) begin
                        r_result <= w_final;
                        r_state  <= S_DONE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign result = r_result;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule

// File: tb/tb_muldiv_unit.sv
// Table-driven and scoreboard bench for muldiv_unit: directed vectors, randomised
// ops against a behavioural model, and hand-written multi-cycle corner sequences.
module tb_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] result;
    logic        busy;
    logic        done;

    int nChecks = 0;
    int nErrors = 0;
    logic [31:0] expQ[$];

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    muldiv_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .result (result),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Behavioural reference built on native wide/signed arithmetic.
    function automatic logic [31:0] refModel(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
        logic [63:0] pu;
        longint      ps;
        int          sa;
        int          sb;
        sa = $signed(a);
        sb = $signed(b);
        pu = {32'b0, a} * {32'b0, b};
        case (f)
            3'b000: return pu[31:0];
            3'b001: begin ps = longint'(sa) * longint'(sb); return ps[63:32]; end
            3'b010: begin ps = longint'(sa) * longint'({32'b0, b}); return ps[63:32]; end
            3'b011: return pu[63:32];
            3'b100: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sa / sb;
            end
            3'b101: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return sa % sb;
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] exp);
        funct3 = f;
        op_a   = a;
        op_b   = b;
        start  = 1'b1;
        expQ.push_back(exp);
    endtask

    // Waits for done (bounded), then checks result, latency and busy duration.
    task automatic checkOutput(input string name, input int lat, input int pokeAt);
        int          edges;
        int          busyCnt;
        logic [31:0] exp;
        @(negedge clk);
        start   = 1'b0;
        edges   = 1;
        busyCnt = busy ? 1 : 0;
        while (!done && edges < 100) begin
            if (edges == pokeAt || edges == pokeAt + 1) begin
                start  = (edges == pokeAt);
                funct3 = 3'($urandom_range(0, 7));
                op_a   = $urandom;
                op_b   = $urandom;
            end
            @(negedge clk);
            edges++;
            if (busy) busyCnt++;
        end
        start = 1'b0;
        exp   = expQ.pop_front();
        if (!done) begin
            nChecks++;
            nErrors++;
            $display("[TB] FAIL %s timeout: no done within %0d cycles, expected result %h",
                     name, edges, exp);
        end else begin
            check({name, " result"}, result, exp);
            check({name, " latency"}, 32'(edges), 32'(lat));
            if (lat > 1) check({name, " busy"}, 32'(busyCnt), 32'(lat - 1));
        end
    endtask

    initial begin
        logic [2:0]  rf;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] discard;

        vecs[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        vecs[1]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
        vecs[2]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        vecs[3]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
        vecs[4]  = '{3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33};
        vecs[5]  = '{3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33};
        vecs[6]  = '{3'b101, 32'd100,        32'd7,         32'd14,        33};
        vecs[7]  = '{3'b111, 32'd100,        32'd7,         32'd2,         33};
        vecs[8]  = '{3'b100, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
        vecs[9]  = '{3'b111, 32'd5,          32'd0,         32'd5,         1};
        vecs[10] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[11] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1};
        vecs[12] = '{3'b101, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 33};
        vecs[13] = '{3'b111, 32'd7,          32'd100,       32'd7,         33};

        rst_n  = 1'b0;
        start  = 1'b0;
        funct3 = '0;
        op_a   = '0;
        op_b   = '0;
        repeat (3) @(negedge clk);
        check("reset result", result, 32'd0);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp);
            checkOutput($sformatf("vec%0d", i), vecs[i].lat, 0);
        end

        for (int i = 0; i < 8; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300));
            @(negedge clk);
            applyStimulus(rf, ra, rb, refModel(rf, ra, rb));
            checkOutput($sformatf("rand%0d f=%0d", i, rf), 33, 0);
        end

        $display("[TB] start and operand changes while busy");
        @(negedge clk);
        applyStimulus(3'b101, 32'd100, 32'd7, 32'd14);
        checkOutput("midcalc", 33, 6);

        $display("[TB] back-to-back launch from DONE");
        applyStimulus(3'b000, 32'd3, 32'd5, 32'd15);
        checkOutput("backtoback", 33, 0);

        $display("[TB] asynchronous reset mid-divide");
        @(negedge clk);
        applyStimulus(3'b100, 32'd1000, 32'd3, 32'd333);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("busy before reset", {31'b0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async reset busy", {31'b0, busy}, 32'd0);
        check("async reset done", {31'b0, done}, 32'd0);
        check("async reset result", result, 32'd0);
        discard = expQ.pop_front();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle after reset", {30'b0, busy, done}, 32'd0);
        applyStimulus(3'b000, 32'd3, 32'd4, 32'd12);
        checkOutput("mul after reset", 33, 0);

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
